pipeline_debug_controller: RTL and testbench
============================================

// Module: pipeline_debug_controller
// PURPOSE
// - Sequences the 5-stage MIPS pipeline from a byte-stream host link (UART rx/tx byte handshakes).
// - Loads program memory, resets the pipeline, runs continuous or single-step, then dumps PC, registers and data memory.
// - Sits between the UART byte interface and the pipeline top; the only driver of its debug/clk_en/reset inputs.
// PARAMETERS
// - NB_DATA        32  data / instruction word width
// - NB_ADDRESS     32  program/data memory byte-address width
// - N_REGISTERS    32  register-file entries dumped
// - N_DUMP_WORDS   16  data-memory words dumped, from byte address 0, step 4
// - NB_ADDR_REGISTERS  $clog2(N_REGISTERS)  register-address width
// PORTS
// - i_clk            in   1     system clock; all state on rising edge
// - i_reset          in   1     asynchronous, active-high reset
// - i_rx_data        in   8     received byte
// - i_rx_valid       in   1     1-cycle strobe: i_rx_data valid
// - o_tx_data        out  8     byte to transmit
// - o_tx_valid       out  1     tx request; held with o_tx_data stable until accepted
// - i_tx_ready       in   1     byte accepted when o_tx_valid & i_tx_ready
// - i_if_pc          in   NB_ADDRESS  pipeline IF PC
// - i_if_halt        in   1     pipeline halt (combinational from ID)
// - i_reg_data       in   NB_DATA     register-file debug read data
// - i_d_mem_data     in   NB_DATA     data-memory debug read data
// - o_debug          out  1     pipeline debug mode (memory/register debug paths selected)
// - o_clk_en         out  1     pipeline clock enable
// - o_pipe_reset     out  1     synchronous pipeline reset pulse
// - o_p_mem_w_en / o_p_mem_w_addr / o_p_mem_w_data  out  1 / NB_ADDRESS / NB_DATA  program-memory write
// - o_d_mem_addr     out  NB_ADDRESS  data-memory debug read address
// - o_reg_addr       out  NB_ADDR_REGISTERS  register debug read address
// BEHAVIOUR
// - Reset: state IDLE; o_debug=1; o_clk_en=0; o_pipe_reset=0; o_tx_valid=0; o_tx_data=0; o_p_mem_w_en=0; all addresses/data 0.
// - Commands, accepted only in IDLE; bytes received outside IDLE and outside LOAD are dropped:
//   - 'L' (0x4C): next byte N gives the word count; 0 means 256. Then 4*N bytes, MSB first.
//     - Each completed word raises o_p_mem_w_en for exactly 1 cycle at addr 0,4,8,...; address counter restarts at 0 per 'L'.
//     - After the last word, tx 0x4B ('K').
//   - 'R' (0x52): o_pipe_reset high 1 cycle; tx 'K'.
//   - 'C' (0x43): RUN state; o_debug=0; o_clk_en = ~i_if_halt (combinational gate, registered state).
//     - First cycle with i_if_halt=1 -> DUMP. If already halted at entry, zero enabled cycles, then DUMP.
//   - 'S' (0x53): o_debug=0, o_clk_en high exactly 1 cycle (0 if i_if_halt=1), then DUMP.
//   - Any other byte: tx 0x3F ('?'), stay IDLE.
// - DUMP (o_debug=1, o_clk_en=0), bytes MSB first:
//   - PC: 4 bytes, sampled on DUMP entry.
//   - Registers: for r=0..N_REGISTERS-1, drive o_reg_addr=r, capture i_reg_data 1 cycle later, send 4 bytes.
//   - Data memory: for k=0..N_DUMP_WORDS-1, o_d_mem_addr=4k, same 1-cycle read latency, 4 bytes.
//   - Total 4+4*N_REGISTERS+4*N_DUMP_WORDS bytes (+4 with option); then IDLE.
// - TX handshake: o_tx_data/o_tx_valid held until i_tx_ready. Next byte is presented no earlier than the cycle after acceptance.
//   - i_tx_ready stuck low stalls DUMP indefinitely without data loss.
// - Sequence: IDLE -> LOAD_CNT -> LOAD_BYTE(x4N, w_en pulse each 4th) -> ACK; IDLE -> RUN|STEP -> DUMP_PC -> DUMP_REG -> DUMP_MEM -> IDLE.
// - Counters: byte index 2 bit, word count 9 bit, reg index NB_ADDR_REGISTERS+1 bit; no wrap within a command.
// - i_reset mid-operation: immediate return to reset values; a partial load leaves earlier-written words in memory.
// CONFIGURATION
// - DBG_CYCLE_COUNT_EN defined: 32-bit counter, cleared by 'R' and reset, +1 per cycle with o_clk_en=1, saturating at 0xFFFFFFFF.
//   - Sent as 4 bytes right after PC in every dump.
// - Undefined: no counter logic; dump format as above.
// TESTING
// - Load: 'L',0x02,12 34 56 78,DE AD BE EF -> w_en pulses addr 0 data 0x12345678, addr 4 data 0xDEADBEEF; tx 'K'.
// - Run: preload program halting after 5 cycles, 'C' -> o_clk_en high exactly 5 cycles; dump starts with halt PC; 4+128+64 bytes total.
// - Step: 'S' x3 from reset -> 3 dumps with PC 0x00000004, 0x00000008, 0x0000000C; one clk_en cycle each.
// - Backpressure: i_tx_ready low 50 cycles mid-dump -> o_tx_data held; byte stream identical to no-stall run.
// - Errors: byte 0x41 in IDLE -> tx 0x3F; 'S' while halted -> 0 clk_en cycles, dump only.
// - Reset: assert i_reset during LOAD_BYTE -> all outputs at reset values same cycle; following 'R' -> 'K'.

Source files
------------

// File: rtl/pipeline_debug_controller.sv
// Host-link debug sequencer for the 5-stage pipeline: program load, pipeline reset, run/step, state dump.
// Optional DBG_CYCLE_COUNT_EN adds a saturating enabled-cycle counter sent right after the PC in each dump.
module pipeline_debug_controller #(
  parameter int NB_DATA           = 32,
  parameter int NB_ADDRESS        = 32,
  parameter int N_REGISTERS       = 32,
  parameter int N_DUMP_WORDS      = 16,
  parameter int NB_ADDR_REGISTERS = $clog2(N_REGISTERS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [7:0]                   i_rx_data,
  input  logic                         i_rx_valid,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  input  logic [NB_ADDRESS-1:0]        i_if_pc,
  input  logic                         i_if_halt,
  input  logic [NB_DATA-1:0]           i_reg_data,
  input  logic [NB_DATA-1:0]           i_d_mem_data,
  output logic                         o_debug,
  output logic                         o_clk_en,
  output logic                         o_pipe_reset,
  output logic                         o_p_mem_w_en,
  output logic [NB_ADDRESS-1:0]        o_p_mem_w_addr,
  output logic [NB_DATA-1:0]           o_p_mem_w_data,
  output logic [NB_ADDRESS-1:0]        o_d_mem_addr,
  output logic [NB_ADDR_REGISTERS-1:0] o_reg_addr
);
  localparam int NB_IDX = NB_ADDR_REGISTERS + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_CNT, S_LOAD_BYTE, S_TX, S_RUN, S_STEP,
    S_DUMP_PC, S_DUMP_CNT, S_DUMP_REG, S_DUMP_MEM
  } state_t;

  state_t                         state_q;
  logic [NB_DATA-1:0]             word_q, cap_d;
  logic [1:0]                     bidx_q, wait_q;
  logic [8:0]                     words_q;
  logic [NB_IDX-1:0]              idx_q;
  logic [NB_ADDRESS-1:0]          load_addr_q;
  logic [7:0]                     tx_data_q;
  logic                           tx_valid_q, pipe_reset_q, w_en_q, running;
  logic [NB_ADDRESS-1:0]          w_addr_q, d_mem_addr_q;
  logic [NB_DATA-1:0]             w_data_q;
  logic [NB_ADDR_REGISTERS-1:0]   reg_addr_q;

  assign running        = (state_q == S_RUN) || (state_q == S_STEP);
  assign o_debug        = ~running;
  assign o_clk_en       = running & ~i_if_halt;
  assign o_tx_data      = tx_data_q;
  assign o_tx_valid     = tx_valid_q;
  assign o_pipe_reset   = pipe_reset_q;
  assign o_p_mem_w_en   = w_en_q;
  assign o_p_mem_w_addr = w_addr_q;
  assign o_p_mem_w_data = w_data_q;
  assign o_d_mem_addr   = d_mem_addr_q;
  assign o_reg_addr     = reg_addr_q;

`ifdef DBG_CYCLE_COUNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cyc_q <= '0;
    else if (state_q == S_IDLE && i_rx_valid && i_rx_data == 8'h52) cyc_q <= '0;
    else if (o_clk_en && cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
  end
`endif

  always_comb begin
    cap_d = i_d_mem_data;
    case (state_q)
      S_DUMP_PC:  cap_d = NB_DATA'(i_if_pc);
`ifdef DBG_CYCLE_COUNT_EN
      S_DUMP_CNT: cap_d = NB_DATA'(cyc_q);
`endif
      S_DUMP_REG: cap_d = i_reg_data;
      default:    cap_d = i_d_mem_data;
    endcase
  end

  // wait_q: 2 = read address just issued, 1 = read data valid this cycle, 0 = word ready to send
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;      word_q <= '0;      bidx_q <= '0;       wait_q <= '0;
      words_q <= '0;          idx_q <= '0;       load_addr_q <= '0;  tx_data_q <= '0;
      tx_valid_q <= 1'b0;     pipe_reset_q <= 1'b0; w_en_q <= 1'b0;  w_addr_q <= '0;
      w_data_q <= '0;         d_mem_addr_q <= '0; reg_addr_q <= '0;
    end else begin
      w_en_q       <= 1'b0;
      pipe_reset_q <= 1'b0;
      case (state_q)
        S_IDLE: if (i_rx_valid) begin
          case (i_rx_data)
            8'h4C: state_q <= S_LOAD_CNT;
            8'h52: begin pipe_reset_q <= 1'b1; tx_data_q <= 8'h4B; tx_valid_q <= 1'b1; state_q <= S_TX; end
            8'h43: state_q <= S_RUN;
            8'h53: state_q <= S_STEP;
            default: begin tx_data_q <= 8'h3F; tx_valid_q <= 1'b1; state_q <= S_TX; end
          endcase
        end
        S_LOAD_CNT: if (i_rx_valid) begin
          words_q     <= (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
          load_addr_q <= '0;
          bidx_q      <= '0;
          state_q     <= S_LOAD_BYTE;
        end
        S_LOAD_BYTE: if (i_rx_valid) begin
          word_q <= {word_q[NB_DATA-9:0], i_rx_data};
          bidx_q <= bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            w_en_q      <= 1'b1;
            w_addr_q    <= load_addr_q;
            w_data_q    <= {word_q[NB_DATA-9:0], i_rx_data};
            load_addr_q <= load_addr_q + NB_ADDRESS'(4);
            words_q     <= words_q - 9'd1;
            if (words_q == 9'd1) begin
              tx_data_q <= 8'h4B; tx_valid_q <= 1'b1; state_q <= S_TX;
            end
          end
        end
        S_TX: if (tx_valid_q && i_tx_ready) begin
          tx_valid_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        S_RUN: if (i_if_halt) begin
          state_q <= S_DUMP_PC; wait_q <= 2'd1; bidx_q <= '0;
        end
        S_STEP: begin
          state_q <= S_DUMP_PC; wait_q <= 2'd1; bidx_q <= '0;
        end
        default: begin
          if (tx_valid_q) begin
            if (i_tx_ready) begin
              tx_valid_q <= 1'b0;
              word_q     <= word_q << 8;
              bidx_q     <= bidx_q + 2'd1;
              if (bidx_q == 2'd3) begin
                case (state_q)
`ifdef DBG_CYCLE_COUNT_EN
                  S_DUMP_PC: begin state_q <= S_DUMP_CNT; wait_q <= 2'd1; end
`endif
                  S_DUMP_REG: begin
                    if (idx_q == NB_IDX'(N_REGISTERS - 1)) begin
                      state_q <= S_DUMP_MEM; idx_q <= '0; d_mem_addr_q <= '0;
                    end else begin
                      idx_q      <= idx_q + 1'b1;
                      reg_addr_q <= NB_ADDR_REGISTERS'(idx_q + 1'b1);
                    end
                    wait_q <= 2'd2;
                  end
                  S_DUMP_MEM: begin
                    if (idx_q == NB_IDX'(N_DUMP_WORDS - 1)) begin
                      state_q <= S_IDLE;
                    end else begin
                      idx_q        <= idx_q + 1'b1;
                      d_mem_addr_q <= NB_ADDRESS'(idx_q + 1'b1) << 2;
                      wait_q       <= 2'd2;
                    end
                  end
                  default: begin
                    state_q <= S_DUMP_REG; idx_q <= '0; reg_addr_q <= '0; wait_q <= 2'd2;
                  end
                endcase
              end
            end
          end else if (wait_q == 2'd2) begin
            wait_q <= 2'd1;
          end else if (wait_q == 2'd1) begin
            wait_q <= 2'd0;
            word_q <= cap_d;
          end else begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= word_q[NB_DATA-1 -: 8];
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Bench for pipeline_debug_controller: behavioural pipeline/memory model, host byte driver,
// and expected dump streams built from the architectural state the dump should report.
module tb_pipeline_debug_controller;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, tx_valid, tx_ready;
  logic [31:0] if_pc, reg_data, d_mem_data, w_addr, w_data, d_mem_addr;
  logic        if_halt, debug, clk_en, pipe_reset, w_en;
  logic [4:0]  reg_addr;

  int compared = 0, mismatched = 0;
  int clk_en_cnt = 0, prst_cnt = 0, hold_viol = 0;
  bit stall = 1'b0, prev_pend = 1'b0;
  logic [7:0]  prev_d = '0;
  logic [7:0]  txq[$];
  logic [63:0] wq[$];
  logic [31:0] regs [32];
  logic [31:0] dmem [16];
  logic [31:0] pmem [256] = '{default: '0};

  always #5 clk = ~clk;

  pipeline_debug_controller dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .i_if_pc(if_pc), .i_if_halt(if_halt), .i_reg_data(reg_data), .i_d_mem_data(d_mem_data),
    .o_debug(debug), .o_clk_en(clk_en), .o_pipe_reset(pipe_reset),
    .o_p_mem_w_en(w_en), .o_p_mem_w_addr(w_addr), .o_p_mem_w_data(w_data),
    .o_d_mem_addr(d_mem_addr), .o_reg_addr(reg_addr)
  );

  // Pipeline stand-in: PC advances by 4 per enabled cycle, halts on HALT_W at the fetched word.
  always @(posedge clk or posedge rst)
    if (rst) if_pc <= '0;
    else if (pipe_reset) if_pc <= '0;
    else if (clk_en) if_pc <= if_pc + 32'd4;
  assign if_halt = (pmem[if_pc[9:2]] === HALT_W);

  always @(posedge clk) begin
    if (w_en) pmem[w_addr[9:2]] <= w_data;
    reg_data   <= regs[reg_addr];
    d_mem_data <= dmem[d_mem_addr[5:2]];
  end

  always @(posedge clk) if (!rst) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (w_en) wq.push_back({w_addr, w_data});
    if (clk_en) clk_en_cnt <= clk_en_cnt + 1;
    if (pipe_reset) prst_cnt <= prst_cnt + 1;
    if (prev_pend && (!tx_valid || tx_data !== prev_d)) hold_viol <= hold_viol + 1;
    prev_pend <= tx_valid && !tx_ready;
    prev_d    <= tx_data;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int c = 0;
    while (txq.size() < n && c < 20000) begin @(negedge clk); c++; end
    repeat (20) @(negedge clk);
  endtask

  task automatic expect_reply(input string tag, input int base, input logic [7:0] b);
    wait_tx(base + 1);
    check({tag, "_len"}, txq.size() - base, 1);
    check(tag, (txq.size() > base) ? txq[base] : 8'hxx, b);
  endtask

  task automatic check_dump(input string tag, input int base, input logic [31:0] exp_pc);
    logic [31:0] words[$];
    logic [7:0]  exp[$];
    int m;
    words.push_back(exp_pc);
    for (int r = 0; r < 32; r++) words.push_back(regs[r]);
    for (int k = 0; k < 16; k++) words.push_back(dmem[k]);
    foreach (words[i]) for (int b = 3; b >= 0; b--) exp.push_back(8'(words[i] >> (8 * b)));
    wait_tx(base + exp.size());
    check({tag, "_len"}, txq.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      m = mismatched;
      check($sformatf("%s_byte%0d", tag, i), (base + i < txq.size()) ? txq[base + i] : 8'hxx, exp[i]);
      if (mismatched != m) break;
    end
  endtask

  initial begin
    int base, wb, c0, p0;
    logic [7:0]  b;
    logic [31:0] prog [6];
    logic [31:0] wd;
    rx_data = '0; rx_valid = 1'b0;
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    for (int k = 0; k < 16; k++) dmem[k] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_debug", debug, 1);        check("rst_clk_en", clk_en, 0);
    check("rst_pipe_reset", pipe_reset, 0); check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);    check("rst_w_en", w_en, 0);
    check("rst_w_addr", w_addr, 0);      check("rst_w_data", w_data, 0);
    check("rst_d_mem_addr", d_mem_addr, 0); check("rst_reg_addr", reg_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed load vector
    base = txq.size(); wb = wq.size();
    send(8'h4C); send(8'h02);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    expect_reply("load_ack", base, 8'h4B);
    check("load_nwords", wq.size() - wb, 2);
    check("load_w0", (wq.size() > wb) ? wq[wb] : 'x, {32'h0, 32'h1234_5678});
    check("load_w1", (wq.size() > wb + 1) ? wq[wb + 1] : 'x, {32'h4, 32'hDEAD_BEEF});

    // Random program that halts once the PC reaches word 5
    for (int i = 0; i < 5; i++) do prog[i] = $urandom; while (prog[i] == HALT_W);
    prog[5] = HALT_W;
    base = txq.size(); wb = wq.size();
    send(8'h4C); send(8'h06);
    for (int i = 0; i < 6; i++) for (int k = 3; k >= 0; k--) send(8'(prog[i] >> (8 * k)));
    expect_reply("prog_ack", base, 8'h4B);
    check("prog_nwords", wq.size() - wb, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("prog_w%0d", i), (wq.size() > wb + i) ? wq[wb + i] : 'x, {32'(4 * i), prog[i]});

    p0 = prst_cnt; base = txq.size();
    send(8'h52);
    expect_reply("reset_ack", base, 8'h4B);
    check("reset_pulses", prst_cnt - p0, 1);

    c0 = clk_en_cnt; base = txq.size();
    send(8'h43);
    check_dump("run", base, 32'd20);
    check("run_clk_en_cycles", clk_en_cnt - c0, 5);

    base = txq.size();
    send(8'h41);
    expect_reply("bad_0x41", base, 8'h3F);
    for (int i = 0; i < 3; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'h4C || b == 8'h52 || b == 8'h43 || b == 8'h53);
      base = txq.size();
      send(b);
      expect_reply($sformatf("bad_rand%0d", i), base, 8'h3F);
    end

    c0 = clk_en_cnt; base = txq.size();
    send(8'h53);
    check_dump("step_halted", base, 32'd20);
    check("step_halted_clk_en", clk_en_cnt - c0, 0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      c0 = clk_en_cnt; base = txq.size();
      send(8'h53);
      check_dump($sformatf("step%0d", s), base, 32'(4 * s));
      check($sformatf("step%0d_clk_en", s), clk_en_cnt - c0, 1);
    end

    // Backpressure: freeze the link for 50 cycles in the middle of a dump
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    for (int k = 0; k < 16; k++) dmem[k] = $urandom;
    base = txq.size();
    send(8'h53);
    c0 = 0;
    while (txq.size() < base + 40 && c0 < 5000) begin @(negedge clk); c0++; end
    stall = 1'b1;
    repeat (50) @(negedge clk);
    check("stall_tx_valid_held", tx_valid, 1);
    stall = 1'b0;
    check_dump("stall", base, 32'd16);

    // Word count 0 means 256 words
    base = txq.size(); wb = wq.size(); wd = '0;
    send(8'h4C); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      wd = $urandom;
      for (int k = 3; k >= 0; k--) send(8'(wd >> (8 * k)));
    end
    expect_reply("load256_ack", base, 8'h4B);
    check("load256_nwords", wq.size() - wb, 256);
    check("load256_last", (wq.size() > 0) ? wq[wq.size() - 1] : 'x, {32'h3FC, wd});

    // Reset in the middle of LOAD_BYTE
    wb = wq.size();
    send(8'h4C); send(8'h03);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); send(8'h5A);
    repeat (2) @(negedge clk);
    check("partial_nwords", wq.size() - wb, 1);
    check("partial_w0", (wq.size() > wb) ? wq[wb] : 'x, {32'h0, 32'hA1A2_A3A4});
    rst = 1'b1;
    #1;
    check("midrst_w_data", w_data, 0);   check("midrst_debug", debug, 1);
    check("midrst_tx_valid", tx_valid, 0); check("midrst_clk_en", clk_en, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    base = txq.size();
    send(8'h52);
    expect_reply("midrst_reset_ack", base, 8'h4B);

    check("tx_hold_violations", hold_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
